// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit-opcode CPU: opcode values, sequencer state
// encoding and the opcode classes used by the sequencer and the control decoder.
package cpu_pkg;

    localparam logic [3:0] OP_FKEQ  = 4'b0000;
    localparam logic [3:0] OP_FKNE  = 4'b0001;
    localparam logic [3:0] OP_FKLT  = 4'b0010;
    localparam logic [3:0] OP_FKLE  = 4'b0011;
    localparam logic [3:0] OP_PLUS  = 4'b0100;
    localparam logic [3:0] OP_MIN   = 4'b0101;
    localparam logic [3:0] OP_AND   = 4'b0110;
    localparam logic [3:0] OP_OR    = 4'b0111;
    localparam logic [3:0] OP_FKGT  = 4'b1000;
    localparam logic [3:0] OP_FKGE  = 4'b1001;
    localparam logic [3:0] OP_JUMP  = 4'b1010;
    localparam logic [3:0] OP_LDW   = 4'b1011;
    localparam logic [3:0] OP_STW   = 4'b1100;
    localparam logic [3:0] OP_PLUSI = 4'b1101;
    localparam logic [3:0] OP_STOP  = 4'b1110;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_CMP,
        CLS_JMP,
        CLS_LDW,
        CLS_STW,
        CLS_STOP,
        CLS_ILL
    } op_class_t;

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode classifier, shared so every consumer agrees on which
// opcodes are ALU, compare, jump, load, store, stop or illegal.
module op_class_decode
    import cpu_pkg::*;
(
    input  logic [3:0] op_code,
    output op_class_t  op_class
);

    always_comb begin
        case (op_code)
            OP_PLUS, OP_MIN, OP_AND, OP_OR, OP_PLUSI:    op_class = CLS_ALU;
            OP_FKEQ, OP_FKNE, OP_FKLT, OP_FKLE,
            OP_FKGT, OP_FKGE:                             op_class = CLS_CMP;
            OP_JUMP:                                      op_class = CLS_JMP;
            OP_LDW:                                       op_class = CLS_LDW;
            OP_STW:                                       op_class = CLS_STW;
            OP_STOP:                                      op_class = CLS_STOP;
            default:                                      op_class = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: decides when PC, IR, register
// file and memory strobes fire, plus halt/resume, memory timeout and retire count.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op_code,
    input  logic             branch_taken,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             reg_we,
    output logic             halted,
    output logic             err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam int              TMO_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit              TMO_EN    = (MEM_TIMEOUT != 0);
    localparam logic [TMO_W-1:0] TMO_LIMIT = (MEM_TIMEOUT > 0) ? TMO_W'(MEM_TIMEOUT - 1) : '0;

    state_t           state_q;
    logic [TMO_W-1:0] tmo_q;
    op_class_t        op_class;
    logic             retire;
    logic             timeout_hit;

    op_class_decode u_op_class_decode (
        .op_code  (op_code),
        .op_class (op_class)
    );

    assign state = state_q;

    // NOTE: every output of this block is given a default first so no path
    // through the case statement can leave a value held, which would infer a latch.
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        reg_we      = 1'b0;
        retire      = 1'b0;
        halted      = (state_q == ST_IDLE) || (state_q == ST_HALT);
        timeout_hit = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req     = 1'b1;
                ir_load     = mem_ack;
                pc_inc      = mem_ack;
                timeout_hit = TMO_EN && !mem_ack && (tmo_q == TMO_LIMIT);
            end
            ST_DECODE: begin
                pc_load = (op_class == CLS_JMP);
                retire  = (op_class == CLS_JMP) || (op_class == CLS_STOP);
            end
            ST_EXEC: begin
                reg_we  = (op_class == CLS_ALU);
                pc_load = (op_class == CLS_CMP) && branch_taken;
                retire  = (op_class == CLS_ALU) || (op_class == CLS_CMP);
            end
            ST_MEM: begin
                mem_req     = 1'b1;
                mem_we      = (op_class == CLS_STW);
                retire      = mem_ack && (op_class == CLS_STW);
                timeout_hit = TMO_EN && !mem_ack && (tmo_q == TMO_LIMIT);
            end
            ST_WB: begin
                reg_we = 1'b1;
                retire = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            err         <= 1'b0;
            instr_count <= '0;
            tmo_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state_q <= ST_FETCH;
                        err     <= 1'b0;
                        tmo_q   <= '0;
                    end
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        state_q <= ST_DECODE;
                        tmo_q   <= '0;
                    end else if (timeout_hit) begin
                        state_q <= ST_HALT;
                        err     <= 1'b1;
                    end else if (TMO_EN) begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_DECODE: begin
                    case (op_class)
                        CLS_STOP: state_q <= ST_HALT;
                        CLS_JMP: begin
                            state_q <= ST_FETCH;
                            tmo_q   <= '0;
                        end
                        CLS_ILL: begin
                            state_q <= ST_HALT;
                            err     <= 1'b1;
                        end
                        default: state_q <= ST_EXEC;
                    endcase
                end
                ST_EXEC: begin
                    // Both successors start a fresh memory request window.
                    state_q <= (op_class == CLS_LDW || op_class == CLS_STW) ? ST_MEM : ST_FETCH;
                    tmo_q   <= '0;
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        state_q <= (op_class == CLS_LDW) ? ST_WB : ST_FETCH;
                        tmo_q   <= '0;
                    end else if (timeout_hit) begin
                        state_q <= ST_HALT;
                        err     <= 1'b1;
                    end else if (TMO_EN) begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_WB: begin
                    state_q <= ST_FETCH;
                    tmo_q   <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase

            if (retire)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed-vector bench: the driver pushes hand-computed per-cycle expectations
// into a scoreboard queue and a separate monitor pops and compares them.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  op_code;
    logic        branch_taken;
    logic        mem_ack;

    logic        mem_req, mem_we, ir_load, pc_inc, pc_load, reg_we, halted, err;
    logic [2:0]  state;
    logic [15:0] instr_count;

    logic        w_mem_req, w_mem_we, w_ir_load, w_pc_inc, w_pc_load, w_reg_we, w_halted, w_err;
    logic [2:0]  w_state;
    logic [3:0]  w_instr_count;

    // Strobe vectors: {mem_req, mem_we, ir_load, pc_inc, pc_load, reg_we}
    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_REQ  = 6'b100000;
    localparam logic [5:0] S_WREQ = 6'b110000;
    localparam logic [5:0] S_FACK = 6'b101100;
    localparam logic [5:0] S_PCL  = 6'b000010;
    localparam logic [5:0] S_WE   = 6'b000001;

    typedef struct {
        logic [2:0]  st;
        logic [5:0]  stb;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    cpu_sequencer #(.CNT_W(16), .MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op_code      (op_code),
        .branch_taken (branch_taken),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .ir_load      (ir_load),
        .pc_inc       (pc_inc),
        .pc_load      (pc_load),
        .reg_we       (reg_we),
        .halted       (halted),
        .err          (err),
        .state        (state),
        .instr_count  (instr_count)
    );

    // Narrow-counter copy on the same stimulus, so the retire count wraps within the run.
    cpu_sequencer #(.CNT_W(4), .MEM_TIMEOUT(4)) u_wrap (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op_code      (op_code),
        .branch_taken (branch_taken),
        .mem_ack      (mem_ack),
        .mem_req      (w_mem_req),
        .mem_we       (w_mem_we),
        .ir_load      (w_ir_load),
        .pc_inc       (w_pc_inc),
        .pc_load      (w_pc_load),
        .reg_we       (w_reg_we),
        .halted       (w_halted),
        .err          (w_err),
        .state        (w_state),
        .instr_count  (w_instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [3:0] op, input logic bt,
                        input logic ack, input logic [2:0] st, input logic [5:0] stb,
                        input logic e, input logic [15:0] cnt);
        exp_t x;
        @(posedge clk);
        #1;
        rst          = r;
        start        = s;
        op_code      = op;
        branch_taken = bt;
        mem_ack      = ack;
        x.st  = st;
        x.stb = stb;
        x.err = e;
        x.cnt = cnt;
        sb.push_back(x);
    endtask

    // Monitor: outputs are sampled on the falling edge, mid-cycle.
    initial begin
        exp_t  x;
        string id;
        logic  exp_halt;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                x = sb.pop_front();
                vectors++;
                id = $sformatf("v%0d", vectors);
                exp_halt = (x.st == 3'd0) || (x.st == 3'd6);
                check({id, " state"},   16'(state), 16'(x.st));
                check({id, " strobes"}, 16'({mem_req, mem_we, ir_load, pc_inc, pc_load, reg_we}), 16'(x.stb));
                check({id, " halted"},  16'(halted), 16'(exp_halt));
                check({id, " err"},     16'(err), 16'(x.err));
                check({id, " count"},   instr_count, x.cnt);
                check({id, " wrap_cnt"}, 16'(w_instr_count), 16'(x.cnt[3:0]));
                check({id, " wrap_out"},
                      16'({w_state, w_mem_req, w_mem_we, w_ir_load, w_pc_inc, w_pc_load, w_reg_we, w_halted, w_err}),
                      16'({x.st, x.stb, exp_halt, x.err}));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        rst = 1'b1; start = 1'b0; op_code = 4'h0; branch_taken = 1'b0; mem_ack = 1'b0;

        // Reset state, then start
        step(1, 0, 4'h0, 0, 0, 3'd0, S_NONE, 0, 16'd0);
        step(0, 0, 4'h0, 0, 1, 3'd0, S_NONE, 0, 16'd0);
        step(0, 1, 4'h0, 0, 0, 3'd0, S_NONE, 0, 16'd0);

        // plus, immediate ack: FETCH, DECODE, EXEC
        step(0, 0, 4'h4, 0, 1, 3'd1, S_FACK, 0, 16'd0);
        step(0, 0, 4'h4, 0, 0, 3'd2, S_NONE, 0, 16'd0);
        step(0, 0, 4'h4, 0, 0, 3'd3, S_WE,   0, 16'd0);

        // ldw, ack arrives in the 4th MEM cycle (the timeout limit cycle)
        step(0, 0, 4'hB, 0, 1, 3'd1, S_FACK, 0, 16'd1);
        step(0, 0, 4'hB, 0, 0, 3'd2, S_NONE, 0, 16'd1);
        step(0, 0, 4'hB, 0, 0, 3'd3, S_NONE, 0, 16'd1);
        step(0, 0, 4'hB, 0, 0, 3'd4, S_REQ,  0, 16'd1);
        step(0, 0, 4'hB, 0, 0, 3'd4, S_REQ,  0, 16'd1);
        step(0, 0, 4'hB, 0, 0, 3'd4, S_REQ,  0, 16'd1);
        step(0, 0, 4'hB, 0, 1, 3'd4, S_REQ,  0, 16'd1);
        step(0, 0, 4'hB, 0, 0, 3'd5, S_WE,   0, 16'd1);

        // stw, immediate ack
        step(0, 0, 4'hC, 0, 1, 3'd1, S_FACK, 0, 16'd2);
        step(0, 0, 4'hC, 0, 0, 3'd2, S_NONE, 0, 16'd2);
        step(0, 0, 4'hC, 0, 0, 3'd3, S_NONE, 0, 16'd2);
        step(0, 0, 4'hC, 0, 1, 3'd4, S_WREQ, 0, 16'd2);

        // fklt taken, then fkeq not taken
        step(0, 0, 4'h2, 0, 1, 3'd1, S_FACK, 0, 16'd3);
        step(0, 0, 4'h2, 0, 0, 3'd2, S_NONE, 0, 16'd3);
        step(0, 0, 4'h2, 1, 0, 3'd3, S_PCL,  0, 16'd3);
        step(0, 0, 4'h0, 0, 1, 3'd1, S_FACK, 0, 16'd4);
        step(0, 0, 4'h0, 0, 0, 3'd2, S_NONE, 0, 16'd4);
        step(0, 0, 4'h0, 0, 0, 3'd3, S_NONE, 0, 16'd4);

        // 13 jumps: two cycles each, carrying the 4-bit copy through its wrap
        for (int i = 0; i < 13; i++) begin
            c = 5 + i;
            step(0, 0, 4'hA, 0, 1, 3'd1, S_FACK, 0, 16'(c));
            step(0, 0, 4'hA, 1, 0, 3'd2, S_PCL,  0, 16'(c));
        end

        // FETCH timeout: 4 request cycles without ack, then HALT with err
        step(0, 0, 4'h4, 0, 0, 3'd1, S_REQ,  0, 16'd18);
        step(0, 0, 4'h4, 0, 0, 3'd1, S_REQ,  0, 16'd18);
        step(0, 0, 4'h4, 0, 0, 3'd1, S_REQ,  0, 16'd18);
        step(0, 0, 4'h4, 0, 0, 3'd1, S_REQ,  0, 16'd18);
        step(0, 0, 4'h4, 0, 0, 3'd6, S_NONE, 1, 16'd18);
        step(0, 0, 4'h4, 0, 1, 3'd6, S_NONE, 1, 16'd18);
        step(0, 1, 4'h4, 0, 0, 3'd6, S_NONE, 1, 16'd18);

        // Resumed with err cleared: stop retires and halts after DECODE
        step(0, 0, 4'hE, 0, 1, 3'd1, S_FACK, 0, 16'd18);
        step(0, 0, 4'hE, 0, 0, 3'd2, S_NONE, 0, 16'd18);
        step(0, 0, 4'hF, 0, 0, 3'd6, S_NONE, 0, 16'd19);
        step(0, 1, 4'hF, 0, 0, 3'd6, S_NONE, 0, 16'd19);

        // Illegal opcode 1111: err, HALT, no retire
        step(0, 0, 4'hF, 0, 1, 3'd1, S_FACK, 0, 16'd19);
        step(0, 0, 4'hF, 0, 0, 3'd2, S_NONE, 0, 16'd19);
        step(0, 0, 4'hF, 0, 0, 3'd6, S_NONE, 1, 16'd19);
        step(0, 1, 4'h4, 0, 0, 3'd6, S_NONE, 1, 16'd19);

        // Asynchronous reset mid-FETCH drops the request within the same cycle
        step(0, 0, 4'h4, 0, 0, 3'd1, S_REQ,  0, 16'd19);
        step(1, 0, 4'h4, 0, 0, 3'd0, S_NONE, 0, 16'd0);
        step(0, 0, 4'h4, 0, 1, 3'd0, S_NONE, 0, 16'd0);

        for (int k = 0; k < 4 && sb.size() != 0; k++)
            @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
